// File: rtl/core_sequencer.sv
// Five-stage instruction sequencer: walks fetch..writeback with one-cycle enable
// pulses, waits on per-stage done levels, and owns pc/mepc/instret and trap redirects.
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    output logic [4:0]  stage_en,
    input  logic [4:0]  stage_done,
    output logic [31:0] pc,
    input  logic        is_jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    input  logic        mret,
    input  logic [31:0] mtvec,
    output logic [31:0] mepc,
    output logic [31:0] instret,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_EN_F, S_WAIT_F,
        S_EN_D, S_WAIT_D,
        S_EN_E, S_WAIT_E,
        S_EN_M, S_WAIT_M,
        S_EN_W, S_WAIT_W,
        S_FAULT
    } state_t;

    typedef struct packed {
        logic        jump;
        logic        exc;
        logic        ret;
        logic [31:0] target;
    } redirect_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t    state;
    state_t    state_next;
    logic [7:0] wait_cnt;
    redirect_t redir;
    logic      in_wait;
    logic      done_sel;
    logic      capture;
    logic      retire;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_next = state;
        stage_en   = 5'b00000;
        in_wait    = 1'b0;
        done_sel   = 1'b0;
        case (state)
            S_IDLE:   if (!halt) state_next = S_EN_F;
            S_EN_F:   begin stage_en = 5'b00001; state_next = S_WAIT_F; end
            S_WAIT_F: begin
                in_wait  = 1'b1;
                done_sel = stage_done[0];
                if (stage_done[0]) state_next = S_EN_D;
            end
            S_EN_D:   begin stage_en = 5'b00010; state_next = S_WAIT_D; end
            S_WAIT_D: begin
                in_wait  = 1'b1;
                done_sel = stage_done[1];
                if (stage_done[1]) state_next = S_EN_E;
            end
            S_EN_E:   begin stage_en = 5'b00100; state_next = S_WAIT_E; end
            S_WAIT_E: begin
                in_wait  = 1'b1;
                done_sel = stage_done[2];
                if (stage_done[2]) state_next = S_EN_M;
            end
            S_EN_M:   begin stage_en = 5'b01000; state_next = S_WAIT_M; end
            S_WAIT_M: begin
                in_wait  = 1'b1;
                done_sel = stage_done[3];
                if (stage_done[3]) state_next = S_EN_W;
            end
            S_EN_W:   begin stage_en = 5'b10000; state_next = S_WAIT_W; end
            S_WAIT_W: begin
                in_wait  = 1'b1;
                done_sel = stage_done[4];
                if (stage_done[4]) state_next = S_IDLE;
            end
            S_FAULT:  state_next = S_FAULT;
            default:  state_next = S_IDLE;
        endcase
        // A stage that has used its whole cycle budget without done is fatal.
        if (in_wait && !done_sel && wait_cnt == WAIT_LAST) state_next = S_FAULT;
    end

    assign capture = (state == S_WAIT_E) && stage_done[2];
    assign retire  = (state == S_WAIT_W) && stage_done[4];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            redir    <= '0;
            pc       <= RESET_PC;
            mepc     <= '0;
            instret  <= '0;
        end else begin
            state <= state_next;

            if (stage_en != 5'b00000)
                wait_cnt <= '0;
            else if (in_wait && !done_sel)
                wait_cnt <= wait_cnt + 8'd1;

            if (capture)
                redir <= '{jump: is_jump, exc: exception, ret: mret, target: jump_target};
            else if (retire)
                redir <= '0;

            if (retire) begin
                if (redir.exc) begin
                    pc   <= mtvec;
                    mepc <= pc;
                end else if (redir.ret) begin
                    pc <= mepc;
                end else if (redir.jump) begin
                    pc <= redir.target;
                end else begin
                    pc <= pc + 32'd1;
                end
                if (!redir.exc) instret <= instret + 32'd1;
            end
        end
    end

    assign busy  = (state != S_IDLE) && (state != S_FAULT);
    assign fault = (state == S_FAULT);

endmodule
